xnor_popcount_layer: RTL and testbench
======================================

XNOR_POPCOUNT_LAYER -- requirements
Module: xnor_popcount_layer

Interface
REQ-001 Parameter IN_W, default 480, input activation vector width in bits.
REQ-002 Parameter OUT_N, default 8, number of output neurons (channels).
REQ-003 Parameter STEPS, default 32, time steps per frame; one weight row per step.
REQ-004 Parameter INIT_FILE, default "output_w.mem", weight image loaded by the ROM sub-module.
REQ-005 clk  input  1  clock, rising-edge active.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  single-cycle pulse; clears step counter and done, opens a new frame.
REQ-008 in_data  input  IN_W  binary activations, 1 = +1, 0 = -1.
REQ-009 in_valid  input  1  in_data valid this cycle.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 thr  input  OUT_N*CW  per-neuron unsigned popcount threshold, CW = clog2(IN_W+1); neuron k uses slice k.
REQ-012 out_bits  output  OUT_N  binarised neuron outputs.
REQ-013 out_pop  output  OUT_N*CW  raw per-neuron popcounts, slice k = neuron k.
REQ-014 out_valid  output  1  out_bits/out_pop/out_step valid, one-cycle pulse per accepted input.
REQ-015 out_step  output  clog2(STEPS)  time step of the current output.
REQ-016 done  output  1  high from last output of a frame until start or reset.

Function
REQ-017 An input is accepted when in_valid && in_ready; in_ready = frame_open && !start.
REQ-018 frame_open is set by start and cleared when the STEPS-th input of the frame is accepted.
REQ-019 Step counter increments per accepted input, 0..STEPS-1; it neither wraps nor saturates past STEPS-1 within a frame.
REQ-020 Stage 0 (accept cycle): in_data and step registered; ROM address = step.
REQ-021 Stage 1: ROM row (OUT_N*IN_W bits, neuron k at [k*IN_W +: IN_W]) valid; per neuron XNOR with in_data and popcount registered into CW bits.
REQ-022 Stage 2: out_bits[k] = (pop_k > thr_k); out_bits, out_pop, out_step, out_valid registered.
REQ-023 Latency is fixed: out_valid rises exactly 3 clk cycles after the accept cycle; throughput 1 input/cycle.
REQ-024 No output backpressure; results are never dropped or duplicated.
REQ-025 done rises in the same cycle as out_valid for out_step == STEPS-1.
REQ-026 start while done is high: done clears next cycle; start while a frame is open: counter restarts at 0, in-flight pipeline results still emerge with their original out_step.
REQ-027 start and in_valid in the same cycle: input is not accepted.
REQ-028 in_valid while !in_ready: ignored, no state change.
REQ-029 Threshold thr_k = IN_W/2 reproduces sign(2*pop - IN_W) with 0 mapped to 0.
REQ-030 Popcount uses full CW width; pop == IN_W (all match) must not overflow.

Reset
REQ-031 On rst_n low, all outputs and state clear: in_ready 0, out_bits 0, out_pop 0, out_valid 0, out_step 0, done 0, step counter 0, frame_open 0, pipeline valid bits 0.
REQ-032 Reset mid-frame discards all in-flight results; no out_valid after reset release until a new start and accepted input.

Structure
REQ-033 CW and step-width functions live in the shared bnn package with the other layer constants.
REQ-034 Weight storage is sub-module xnor_weight_rom (synchronous read, 1-cycle latency, depth STEPS, width OUT_N*IN_W, enable = pipeline advance).
REQ-035 Popcount is a generate-loop adder tree per neuron, not a hand-unrolled sum.

Verification
REQ-036 Defaults, thr all 240, ROM row 0 = in_data for neuron 0, ~in_data for neuron 1 -> out_pop0 480, out_bits[0] 1, out_pop1 0, out_bits[1] 0, 3 cycles after accept.
REQ-037 start then 32 back-to-back inputs -> 32 out_valid pulses, out_step 0..31, done high with step 31, in_ready low after 32nd accept.
REQ-038 pop exactly 240 with thr 240 -> out_bit 0; pop 241 -> out_bit 1.
REQ-039 start asserted with in_valid at step 5 -> that input dropped, next accepted input reports out_step 0; in-flight steps 3,4 still output.
REQ-040 rst_n pulsed low at step 10 with 2 results in flight -> no out_valid after release, done 0, in_ready 0 until start.
REQ-041 Random in_valid gaps (50% duty), random thr -> out_bits/out_pop match reference model per step, order preserved.

Source files
------------

// File: rtl/xnor_popcount_layer_pkg.sv
// Shared constants and helpers for the binary (XNOR/popcount) layer.
//   DEF_*  : default layer geometry
//   cw_f   : popcount width able to hold 0..w inclusive
//   sw_f   : step-index width (at least 1 bit)
//   frame_st_e : frame-control state
package xnor_popcount_layer_pkg;

  localparam int DEF_IN_W  = 480;
  localparam int DEF_OUT_N = 8;
  localparam int DEF_STEPS = 32;

  typedef enum logic {ST_IDLE, ST_RUN} frame_st_e;

  function automatic int cw_f(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int sw_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xnor_popcount_layer_if.sv
// Activation/result bus of the XNOR popcount layer.
//   master : frame start, activations + valid, per-neuron thresholds; sees
//            in_ready and the registered neuron results.
//   slave  : the layer itself.
interface xnor_popcount_layer_if
  import xnor_popcount_layer_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_N = DEF_OUT_N,
  parameter int STEPS = DEF_STEPS
);
  localparam int CW = cw_f(IN_W);
  localparam int SW = sw_f(STEPS);

  logic                  start;
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [OUT_N*CW-1:0]   thr;
  logic [OUT_N-1:0]      out_bits;
  logic [OUT_N*CW-1:0]   out_pop;
  logic                  out_valid;
  logic [SW-1:0]         out_step;
  logic                  done;

  modport master (
    output start, in_data, in_valid, thr,
    input  in_ready, out_bits, out_pop, out_valid, out_step, done
  );

  modport slave (
    input  start, in_data, in_valid, thr,
    output in_ready, out_bits, out_pop, out_valid, out_step, done
  );

endinterface

// File: rtl/xnor_popcount_layer_lane.sv
// One neuron: XNOR activations against its weight row, adder-tree popcount
// (registered, stage 1), then threshold compare (registered, stage 2).
//   s1_en_i : stage-1 capture (act_i/w_i valid)
//   s2_en_i : stage-2 capture
//   thr_i   : unsigned threshold, bit = pop > thr
//   pop_o / bit_o : registered popcount and binarised output
module xnor_popcount_layer_lane #(
  parameter int IN_W = 480,
  parameter int CW   = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s1_en_i,
  input  logic [IN_W-1:0] act_i,
  input  logic [IN_W-1:0] w_i,
  input  logic            s2_en_i,
  input  logic [CW-1:0]   thr_i,
  output logic [CW-1:0]   pop_o,
  output logic            bit_o
);

  localparam int LV = $clog2(IN_W);
  localparam int P  = 1 << LV;

  logic [IN_W-1:0] xn;
  logic [CW-1:0]   pop_d;
  logic [CW-1:0]   pop_s1_q;
  logic [CW-1:0]   pop_q;
  logic            bit_q;

  assign xn = ~(act_i ^ w_i);

  // Binary tree padded to a power of two; every node is CW wide, so the
  // all-match total IN_W is representable at the root.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [N-1:0][CW-1:0] s;
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < N; i++) begin : g_i
        if (i < IN_W) begin : g_b
          assign s[i] = CW'(xn[i]);
        end else begin : g_z
          assign s[i] = '0;
        end
      end
    end else begin : g_add
      for (genvar i = 0; i < N; i++) begin : g_i
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign pop_d = g_lvl[LV].s[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_s1_q <= '0;
      pop_q    <= '0;
      bit_q    <= 1'b0;
    end else begin
      if (s1_en_i) pop_s1_q <= pop_d;
      if (s2_en_i) begin
        pop_q <= pop_s1_q;
        bit_q <= (pop_s1_q > thr_i);
      end
    end
  end

  assign pop_o = pop_q;
  assign bit_o = bit_q;

endmodule

// File: rtl/xnor_weight_rom.sv
module xnor_weight_rom #(
  parameter int    DEPTH     = 32,
  parameter int    WIDTH     = 3840,
  parameter int    AW        = 5,
  parameter string INIT_FILE = "output_w.mem"
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [AW-1:0]    addr_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en_i) rd_q <= mem_q[addr_i];
  end

  assign data_o = rd_q;

endmodule

// File: rtl/xnor_popcount_layer.sv
// Binary neural layer: per time step one activation vector is XNORed with
// that step's weight row for every neuron, popcounted and thresholded.
// Fixed 3-cycle latency, one input per cycle, no output backpressure.
//   clk, rst_n : clock, async active-low reset
//   bus (slave): start/in_data/in_valid/thr in; in_ready, out_bits,
//                out_pop, out_valid, out_step, done out
module xnor_popcount_layer
  import xnor_popcount_layer_pkg::*;
#(
  parameter int    IN_W      = DEF_IN_W,
  parameter int    OUT_N     = DEF_OUT_N,
  parameter int    STEPS     = DEF_STEPS,
  parameter string INIT_FILE = "output_w.mem"
) (
  input logic                  clk,
  input logic                  rst_n,
  xnor_popcount_layer_if.slave bus
);

  localparam int CW     = cw_f(IN_W);
  localparam int SW     = sw_f(STEPS);
  localparam int STAGES = 2;
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  frame_st_e             st_q, st_d;
  logic [SW-1:0]         step_q, step_d;
  logic                  done_q, done_d;
  logic                  accept;

  logic [STAGES:0]       vld_pipe_q;
  logic [IN_W-1:0]       data_s0_q;
  logic [SW-1:0]         step_s0_q;
  logic [SW-1:0]         step_s1_q;
  logic [SW-1:0]         out_step_q;
  logic [OUT_N*IN_W-1:0] row;

  logic [OUT_N-1:0][CW-1:0] pop_w;
  logic [OUT_N-1:0]         bits_w;

  // start wins over a simultaneous in_valid: the input is simply not taken.
  assign bus.in_ready = (st_q == ST_RUN) && !bus.start;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    done_d = done_q;
    if (vld_pipe_q[1] && (step_s1_q == LAST)) done_d = 1'b1;
    if (bus.start) begin
      st_d   = ST_RUN;
      step_d = '0;
      done_d = 1'b0;
    end else if (accept) begin
      // Last step closes the frame; the counter holds rather than wraps.
      if (step_q == LAST) st_d = ST_IDLE;
      else                step_d = step_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      step_q     <= '0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      data_s0_q  <= '0;
      step_s0_q  <= '0;
      step_s1_q  <= '0;
      out_step_q <= '0;
    end else begin
      st_q       <= st_d;
      step_q     <= step_d;
      done_q     <= done_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], accept};
      if (accept) begin
        data_s0_q <= bus.in_data;
        step_s0_q <= step_q;
      end
      if (vld_pipe_q[0]) step_s1_q  <= step_s0_q;
      if (vld_pipe_q[1]) out_step_q <= step_s1_q;
    end
  end

  // Row for the accepted step lands alongside data_s0_q.
  xnor_weight_rom #(
    .DEPTH     (STEPS),
    .WIDTH     (OUT_N * IN_W),
    .AW        (SW),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .en_i   (accept),
    .addr_i (step_q),
    .data_o (row)
  );

  for (genvar k = 0; k < OUT_N; k++) begin : g_lane
    xnor_popcount_layer_lane #(
      .IN_W (IN_W),
      .CW   (CW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .s1_en_i (vld_pipe_q[0]),
      .act_i   (data_s0_q),
      .w_i     (row[k*IN_W +: IN_W]),
      .s2_en_i (vld_pipe_q[1]),
      .thr_i   (bus.thr[k*CW +: CW]),
      .pop_o   (pop_w[k]),
      .bit_o   (bits_w[k])
    );
  end

  assign bus.out_bits  = bits_w;
  assign bus.out_pop   = pop_w;
  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.out_step  = out_step_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_xnor_popcount_layer.sv
module tb_xnor_popcount_layer;

  localparam int IN_W  = 480;
  localparam int OUT_N = 8;
  localparam int STEPS = 32;
  localparam int CW    = $clog2(IN_W + 1);
  localparam int SW    = $clog2(STEPS);

  typedef struct {
    logic [SW-1:0]       step;
    logic [OUT_N*CW-1:0] pop;
    logic [OUT_N-1:0]    bits;
    int                  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;

  exp_t sb[$];
  exp_t me;
  logic [OUT_N*IN_W-1:0] w_mem [STEPS];
  logic [OUT_N*CW-1:0]   thr_v;
  bit   m_open = 1'b0;
  int   m_step = 0;

  xnor_popcount_layer_if #(.IN_W(IN_W), .OUT_N(OUT_N), .STEPS(STEPS)) bus ();

  xnor_popcount_layer #(
    .IN_W(IN_W), .OUT_N(OUT_N), .STEPS(STEPS), .INIT_FILE("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [IN_W-1:0] rnd_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [OUT_N*IN_W-1:0] rnd_row();
    logic [OUT_N*IN_W-1:0] r;
    for (int k = 0; k < OUT_N; k++) r[k*IN_W +: IN_W] = rnd_vec();
    return r;
  endfunction

  // Reference: pop = number of matching bits, bit = pop > thr.
  function automatic exp_t model(input int st, input logic [IN_W-1:0] d);
    exp_t e;
    int   p;
    e.step = SW'(st);
    e.cyc  = cyc;
    for (int k = 0; k < OUT_N; k++) begin
      p = IN_W - $countones(d ^ w_mem[st][k*IN_W +: IN_W]);
      e.pop[k*CW +: CW] = CW'(p);
      e.bits[k] = (p > int'(thr_v[k*CW +: CW]));
    end
    return e;
  endfunction

  task automatic set_row(input int r, input logic [OUT_N*IN_W-1:0] w);
    w_mem[r] = w;
    dut.u_rom.mem_q[r] = w;
  endtask

  // Called just after a rising edge; drives one cycle of stimulus.
  task automatic step_in(input logic s, input logic v, input logic [IN_W-1:0] d);
    bus.start    = s;
    bus.in_valid = v;
    bus.in_data  = d;
    @(negedge clk);
    chk("in_ready", bus.in_ready, m_open && !s);
    if (v && m_open && !s) begin
      sb.push_back(model(m_step, d));
      if (m_step == STEPS - 1) m_open = 1'b0;
      else m_step++;
    end
    if (s) begin
      m_open = 1'b1;
      m_step = 0;
    end
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", bus.out_valid, 1'b0);
      end else begin
        me = sb.pop_front();
        n_out++;
        chk("out_step", bus.out_step, me.step);
        chk("out_pop", bus.out_pop, me.pop);
        chk("out_bits", bus.out_bits, me.bits);
        chk("latency", cyc, me.cyc + 3);
        if (me.step == SW'(STEPS - 1)) chk("done_with_last", bus.done, 1'b1);
      end
    end
  end

  initial begin
    logic [IN_W-1:0]       d0, d1, m240, m239;
    logic [OUT_N*IN_W-1:0] row;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int k = 0; k < OUT_N; k++) thr_v[k*CW +: CW] = CW'(IN_W / 2);
    bus.thr = thr_v;

    for (int r = 0; r < STEPS; r++) set_row(r, rnd_row());
    d0  = rnd_vec();
    row = w_mem[0];
    row[0 +: IN_W]    = d0;
    row[IN_W +: IN_W] = ~d0;
    set_row(0, row);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_bits", bus.out_bits, '0);
    chk("rst_out_pop", bus.out_pop, '0);
    chk("rst_out_step", bus.out_step, '0);
    chk("rst_done", bus.done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // No frame open: input ignored
    step_in(1'b0, 1'b1, rnd_vec());

    // Full frame, back-to-back; step 0 gives pop 480 / 0 on neurons 0 / 1
    n_out = 0;
    step_in(1'b1, 1'b0, '0);
    chk("done_low_in_frame", bus.done, 1'b0);
    for (int i = 0; i < STEPS; i++) step_in(1'b0, 1'b1, (i == 0) ? d0 : rnd_vec());
    step_in(1'b0, 1'b1, rnd_vec());
    drain();
    chk("frameA_pulses", n_out, STEPS);
    chk("frameA_done", bus.done, 1'b1);

    // Threshold boundary: pop 240 -> 0, pop 241 -> 1
    d1 = rnd_vec();
    m240 = '0;
    m239 = '0;
    for (int i = 0; i < 240; i++) m240[i] = 1'b1;
    for (int i = 0; i < 239; i++) m239[i] = 1'b1;
    row = w_mem[0];
    row[0 +: IN_W]    = d1 ^ m240;
    row[IN_W +: IN_W] = d1 ^ m239;
    set_row(0, row);

    // Restart mid-frame with a colliding input
    n_out = 0;
    step_in(1'b1, 1'b0, '0);
    chk("done_cleared_by_start", bus.done, 1'b0);
    step_in(1'b0, 1'b1, d1);
    for (int i = 1; i < 5; i++) step_in(1'b0, 1'b1, rnd_vec());
    step_in(1'b1, 1'b1, rnd_vec());
    for (int i = 0; i < STEPS; i++) step_in(1'b0, 1'b1, rnd_vec());
    drain();
    chk("frameB_pulses", n_out, 5 + STEPS);
    chk("frameB_done", bus.done, 1'b1);

    // Reset mid-frame with two results in flight
    step_in(1'b1, 1'b0, '0);
    for (int i = 0; i < 11; i++) step_in(1'b0, 1'b1, rnd_vec());
    @(negedge clk);
    #1;
    n_out  = 0;
    rst_n  = 1'b0;
    sb.delete();
    m_open = 1'b0;
    m_step = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step_in(1'b0, 1'b1, rnd_vec());
    chk("postrst_done", bus.done, 1'b0);
    chk("postrst_no_output", n_out, 0);

    // Random gaps, random thresholds
    set_row(0, rnd_row());
    for (int k = 0; k < OUT_N; k++) thr_v[k*CW +: CW] = CW'($urandom_range(200, 280));
    bus.thr = thr_v;
    n_out = 0;
    step_in(1'b1, 1'b0, '0);
    for (int i = 0; i < 400 && m_open; i++)
      step_in(1'b0, 1'($urandom_range(0, 1)), rnd_vec());
    drain();
    chk("frameD_pulses", n_out, STEPS);
    chk("frameD_done", bus.done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
